// File: rtl/ifu_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch_ctrl_pkg
// Description : Shared constants, state encoding and helpers for the fetch
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package ifu_fetch_ctrl_pkg;

    localparam logic [31:0] c_nop_insn         = 32'h0000_0013;
    localparam logic [63:0] c_reset_pc_default = 64'h0000_0000_8000_0000;

    localparam int c_state_w = 2;
    typedef logic [c_state_w-1:0] fetch_state_t;

    localparam fetch_state_t c_st_run   = 2'd0;
    localparam fetch_state_t c_st_drain = 2'd1;
    localparam fetch_state_t c_st_exc   = 2'd2;

    // Targets are 32-bit instruction aligned; anything else raises a fetch fault.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_fetch_ctrl_credit_ctr.sv
`default_nettype none
// ============================================================================
// Module      : fetch_credit_ctr
// Description : Saturating up/down counter with synchronous load; increments
//               and decrements arriving on the same cycle are summed.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_credit_ctr #(
    parameter int WIDTH   = 3,
    parameter int MAX     = 7,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic [WIDTH-1:0] i_inc,
    input  logic [WIDTH-1:0] i_dec,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH:0]   c_max     = (WIDTH+1)'(MAX);
    localparam logic [WIDTH-1:0] c_rst_val = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;

    // One extra bit of headroom so the sum can never wrap before saturation.
    always_comb begin
        w_sum  = {1'b0, r_count} + {1'b0, i_inc};
        w_diff = w_sum - {1'b0, i_dec};
        if (i_load) begin
            w_next = i_load_val;
        end else if (w_sum < {1'b0, i_dec}) begin
            w_next = '0;
        end else if (w_diff > c_max) begin
            w_next = c_max[WIDTH-1:0];
        end else begin
            w_next = w_diff[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= c_rst_val;
        end else begin
            r_count <= w_next;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/ifu_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch_ctrl
// Description : Fetch sequencer: issues 64-bit aligned imem fetches under
//               queue credit control, writes responses into the instruction
//               queue and handles redirect, flush and misaligned targets.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch_ctrl
    import ifu_fetch_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(c_reset_pc_default),
    parameter int                    QUEUE_SLOTS = 7,
    parameter int                    MAX_OUTST   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
    output logic                  imem_req_valid_o,
    output logic [ADDR_WIDTH-1:0] imem_req_addr_o,
    input  logic                  imem_req_ready_i,
    input  logic                  imem_rsp_valid_i,
    input  logic [63:0]           imem_rsp_data_i,
    input  logic                  q_deq_i,
    output logic                  q_flush_o,
    output logic [31:0]           q_inst0_o,
    output logic [31:0]           q_inst1_o,
    output logic                  q_inst_valid_o,
    output logic                  q_misalign_o,
    output logic [ADDR_WIDTH-1:0] q_misalign_addr_o
);

    localparam int c_cred_w  = $clog2(QUEUE_SLOTS + 1);
    localparam int c_outst_w = $clog2(MAX_OUTST + 1);

    localparam logic [c_cred_w-1:0]  c_slots     = c_cred_w'(QUEUE_SLOTS);
    localparam logic [c_outst_w-1:0] c_max_outst = c_outst_w'(MAX_OUTST);

    fetch_state_t             r_state;
    fetch_state_t             w_state_next;
    logic [ADDR_WIDTH-1:0]    r_pc;
    logic                     r_first_hi;

    logic [c_cred_w-1:0]      w_credits;
    logic [c_cred_w-1:0]      w_occ;
    logic [c_outst_w-1:0]     w_outst;
    logic [c_outst_w-1:0]     w_drop;

    logic                     w_redirect;
    logic                     w_exc_tgt;
    logic                     w_exc_wr;
    logic                     w_req_valid;
    logic                     w_hs;
    logic                     w_rsp_drop;
    logic                     w_rsp_wr;
    logic                     w_deq;
    logic [c_outst_w-1:0]     w_drop_load;
    logic [c_outst_w-1:0]     w_drop_dec;
    logic [c_cred_w-1:0]      w_cred_load;

    logic                     r_inst_valid;
    logic [31:0]              r_inst0;
    logic [31:0]              r_inst1;
    logic                     r_misalign;
    logic [ADDR_WIDTH-1:0]    r_misalign_addr;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    assign w_redirect = redirect_valid_i;
    assign w_exc_tgt  = is_misaligned(redirect_addr_i[1:0]);
    assign w_exc_wr   = w_redirect && w_exc_tgt;
    assign w_hs       = w_req_valid && imem_req_ready_i;

    // A response is kept only if no redirect is in progress and no stale fetch is pending.
    assign w_rsp_drop = imem_rsp_valid_i &&
                        (w_redirect || (w_drop != '0) || (r_state == c_st_exc));
    assign w_rsp_wr   = imem_rsp_valid_i && !w_rsp_drop;
    assign w_deq      = q_deq_i && !w_redirect && (w_occ != '0);

    // Requests still in flight after a redirect cycle; they all become stale.
    assign w_drop_load = w_outst - c_outst_w'(imem_rsp_valid_i);
    assign w_drop_dec  = (w_rsp_drop && (w_drop != '0)) ? (w_drop - 1'b1) : w_drop;
    assign w_cred_load = c_slots - c_cred_w'(w_drop_load) - c_cred_w'(w_exc_wr);

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    fetch_credit_ctr #(
        .WIDTH   (c_cred_w),
        .MAX     (QUEUE_SLOTS),
        .RST_VAL (QUEUE_SLOTS)
    ) u_credits (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_redirect),
        .i_load_val (w_cred_load),
        .i_inc      (c_cred_w'(w_rsp_drop) + c_cred_w'(w_deq)),
        .i_dec      (c_cred_w'(w_hs)),
        .o_count    (w_credits)
    );

    fetch_credit_ctr #(
        .WIDTH   (c_cred_w),
        .MAX     (QUEUE_SLOTS),
        .RST_VAL (0)
    ) u_occ (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_redirect),
        .i_load_val (c_cred_w'(w_exc_wr)),
        .i_inc      (c_cred_w'(w_rsp_wr)),
        .i_dec      (c_cred_w'(w_deq)),
        .o_count    (w_occ)
    );

    fetch_credit_ctr #(
        .WIDTH   (c_outst_w),
        .MAX     (MAX_OUTST),
        .RST_VAL (0)
    ) u_outst (
        .clk        (clk),
        .rst        (rst),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_inc      (c_outst_w'(w_hs)),
        .i_dec      (c_outst_w'(imem_rsp_valid_i)),
        .o_count    (w_outst)
    );

    fetch_credit_ctr #(
        .WIDTH   (c_outst_w),
        .MAX     (MAX_OUTST),
        .RST_VAL (0)
    ) u_drop (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_redirect),
        .i_load_val (w_drop_load),
        .i_inc      ('0),
        .i_dec      (c_outst_w'(w_rsp_drop)),
        .o_count    (w_drop)
    );

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_run;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_redirect) begin
            if (w_exc_tgt) begin
                w_state_next = c_st_exc;
            end else if (w_drop_load != '0) begin
                w_state_next = c_st_drain;
            end else begin
                w_state_next = c_st_run;
            end
        end else begin
            case (r_state)
                c_st_run: w_state_next = c_st_run;
                c_st_drain: begin
                    if (w_drop_dec == '0) begin
                        w_state_next = c_st_run;
                    end
                end
                c_st_exc: w_state_next = c_st_exc;
                default:  w_state_next = c_st_run;
            endcase
        end
    end

    // Reset is folded in so no request is visible while the block is held in reset.
    always_comb begin
        w_req_valid      = rst && (r_state == c_st_run) && (w_credits != '0) &&
                           (w_outst < c_max_outst) && !w_redirect;
        imem_req_valid_o = w_req_valid;
        imem_req_addr_o  = w_req_valid ? r_pc : '0;
    end

    // ------------------------------------------------------------------
    // Fetch PC and first-block lower-slot suppression
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_first_hi <= 1'b0;
        end else if (w_redirect) begin
            r_pc       <= {redirect_addr_i[ADDR_WIDTH-1:3], 3'b000};
            r_first_hi <= !w_exc_tgt && redirect_addr_i[2];
        end else begin
            if (w_hs) begin
                r_pc <= r_pc + ADDR_WIDTH'(8);
            end
            if (w_rsp_wr) begin
                r_first_hi <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Queue write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inst_valid    <= 1'b0;
            r_inst0         <= '0;
            r_inst1         <= '0;
            r_misalign      <= 1'b0;
            r_misalign_addr <= '0;
        end else begin
            r_inst_valid <= w_rsp_wr || w_exc_wr;
            r_misalign   <= w_exc_wr;
            if (w_exc_wr) begin
                r_inst0         <= '0;
                r_inst1         <= '0;
                r_misalign_addr <= redirect_addr_i;
            end else if (w_rsp_wr) begin
                r_inst0 <= r_first_hi ? c_nop_insn : imem_rsp_data_i[31:0];
                r_inst1 <= imem_rsp_data_i[63:32];
            end
        end
    end

    assign q_flush_o         = redirect_valid_i;
    assign q_inst_valid_o    = r_inst_valid;
    assign q_inst0_o         = r_inst0;
    assign q_inst1_o         = r_inst1;
    assign q_misalign_o      = r_misalign;
    assign q_misalign_addr_o = r_misalign_addr;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_fetch_ctrl
// Description : Randomized self-checking bench for ifu_fetch_ctrl with a
//               behavioural fetch/queue model and an entry scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch_ctrl;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int          SLOTS    = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [63:0] redirect_addr_i  = '0;
    logic        imem_req_valid_o;
    logic [63:0] imem_req_addr_o;
    logic        imem_req_ready_i = 1'b0;
    logic        imem_rsp_valid_i = 1'b0;
    logic [63:0] imem_rsp_data_i  = '0;
    logic        q_deq_i = 1'b0;
    logic        q_flush_o;
    logic [31:0] q_inst0_o;
    logic [31:0] q_inst1_o;
    logic        q_inst_valid_o;
    logic        q_misalign_o;
    logic [63:0] q_misalign_addr_o;

    ifu_fetch_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .redirect_valid_i  (redirect_valid_i),
        .redirect_addr_i   (redirect_addr_i),
        .imem_req_valid_o  (imem_req_valid_o),
        .imem_req_addr_o   (imem_req_addr_o),
        .imem_req_ready_i  (imem_req_ready_i),
        .imem_rsp_valid_i  (imem_rsp_valid_i),
        .imem_rsp_data_i   (imem_rsp_data_i),
        .q_deq_i           (q_deq_i),
        .q_flush_o         (q_flush_o),
        .q_inst0_o         (q_inst0_o),
        .q_inst1_o         (q_inst1_o),
        .q_inst_valid_o    (q_inst_valid_o),
        .q_misalign_o      (q_misalign_o),
        .q_misalign_addr_o (q_misalign_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] i0;
        logic [31:0] i1;
        logic        mis;
        logic [63:0] maddr;
    } ent_t;

    typedef struct packed {
        int unsigned cyc;
        logic        stale;
    } rec_t;

    ent_t        sb[$];
    rec_t        infl[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int          hs_count = 0;
    int          model_occ = 0;
    int          slots_used = 0;
    logic [63:0] exp_addr = RESET_PC;
    logic [63:0] last_exc = '0;
    logic        first_hi = 1'b0;
    logic        in_exc = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_valid", 64'(imem_req_valid_o), 64'd0);
        chk("rst_req_addr", imem_req_addr_o, 64'd0);
        chk("rst_inst_valid", 64'(q_inst_valid_o), 64'd0);
        chk("rst_inst", {q_inst1_o, q_inst0_o}, 64'd0);
        chk("rst_misalign", 64'(q_misalign_o), 64'd0);
        chk("rst_misalign_addr", q_misalign_addr_o, 64'd0);
        chk("rst_flush", 64'(q_flush_o), 64'(redirect_valid_i));
    endtask

    task automatic model_reset();
        sb.delete();
        infl.delete();
        model_occ  = 0;
        slots_used = 0;
        exp_addr   = RESET_PC;
        last_exc   = '0;
        first_hi   = 1'b0;
        in_exc     = 1'b0;
    endtask

    // Monitor: every queue write is matched against the head of the scoreboard.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (rst && q_inst_valid_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_entry: got inst0=%h inst1=%h mis=%b expected no write", q_inst0_o, q_inst1_o, q_misalign_o);
                end else begin
                    e = sb.pop_front();
                    chk("entry_data", {q_inst1_o, q_inst0_o}, {e.i1, e.i0});
                    chk("entry_misalign", {63'd0, q_misalign_o}, {63'd0, e.mis});
                    chk("entry_misalign_addr", q_misalign_addr_o, e.maddr);
                end
                if (!redirect_valid_i) model_occ++;
            end
        end
    end

    // One clock of stimulus followed by the reference-model update for that clock.
    task automatic step(input logic redir, input logic [63:0] raddr,
                        input int p_rdy, input int p_rsp, input int p_deq);
        logic hs;
        logic mis;
        rec_t r;
        ent_t e;
        @(posedge clk);
        #1;
        cyc++;
        redirect_valid_i = redir;
        redirect_addr_i  = redir ? raddr : 64'($urandom);
        imem_req_ready_i = ($urandom_range(99) < p_rdy);
        imem_rsp_valid_i = (infl.size() > 0) && (infl[0].cyc < cyc) && ($urandom_range(99) < p_rsp);
        imem_rsp_data_i  = {$urandom, $urandom};
        q_deq_i          = (model_occ > 0) && !redir && ($urandom_range(99) < p_deq);
        @(negedge clk);
        hs = imem_req_valid_o && imem_req_ready_i;
        mis = (raddr[1:0] != 2'b00);
        if (redir) begin
            chk("flush_follows_redirect", 64'(q_flush_o), 64'd1);
            chk("no_req_on_redirect", 64'(imem_req_valid_o), 64'd0);
        end
        if (hs) begin
            chk("req_addr", imem_req_addr_o, exp_addr);
            chk("credit_limit", 64'(slots_used < SLOTS), 64'd1);
            chk("no_issue_while_stale", 64'(infl.size() > 0 && infl[infl.size()-1].stale), 64'd0);
            chk("no_issue_in_exc", 64'(in_exc), 64'd0);
        end
        if (imem_rsp_valid_i) begin
            r = infl.pop_front();
            if (!r.stale && !redir) begin
                e.i0    = first_hi ? NOP : imem_rsp_data_i[31:0];
                e.i1    = imem_rsp_data_i[63:32];
                e.mis   = 1'b0;
                e.maddr = last_exc;
                first_hi = 1'b0;
                sb.push_back(e);
            end else begin
                slots_used--;
            end
        end
        if (q_deq_i) begin
            model_occ--;
            slots_used--;
        end
        if (hs) begin
            r.cyc   = cyc;
            r.stale = 1'b0;
            infl.push_back(r);
            exp_addr = exp_addr + 64'd8;
            slots_used++;
            hs_count++;
        end
        if (redir) begin
            for (int i = 0; i < infl.size(); i++) infl[i].stale = 1'b1;
            model_occ  = 0;
            slots_used = infl.size();
            in_exc     = mis;
            first_hi   = !mis && raddr[2];
            if (mis) begin
                e.i0 = '0;
                e.i1 = '0;
                e.mis = 1'b1;
                e.maddr = raddr;
                last_exc = raddr;
                sb.push_back(e);
                slots_used++;
            end else begin
                exp_addr = {raddr[63:3], 3'b000};
            end
        end
    endtask

    task automatic idle_inputs();
        redirect_valid_i = 1'b0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        q_deq_i          = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          base;
        int          n;
        logic [63:0] tgt;
        logic [15:0] rnd16;

        // Reset state
        redirect_valid_i = 1'b1;
        #2;
        chk("rst_flush_comb", 64'(q_flush_o), 64'd1);
        redirect_valid_i = 1'b0;
        #1;
        check_reset_outputs();
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // 1: in-order fetch and write-back
        for (int i = 0; i < 25; i++) step(1'b0, '0, 100, 80, 60);

        // 2: credit exhaustion with no dequeue, then a single dequeue
        step(1'b1, RESET_PC, 100, 100, 0);
        base = hs_count;
        for (int i = 0; i < 30; i++) step(1'b0, '0, 100, 100, 0);
        chk("credit_exhaust_hs", 64'(hs_count - base), 64'd7);
        base = hs_count;
        step(1'b0, '0, 100, 100, 100);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 100, 100, 0);
        chk("one_deq_one_req", 64'(hs_count - base), 64'd1);

        // 3: redirect with two requests in flight
        for (int i = 0; i < 15; i++) step(1'b0, '0, 100, 100, 100);
        n = 0;
        while (infl.size() < 2 && n < 20) begin
            step(1'b0, '0, 100, 0, 100);
            n++;
        end
        chk("two_outstanding", 64'(infl.size()), 64'd2);
        step(1'b1, 64'h8000_0200, 100, 0, 0);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 100, 70, 50);

        // 4: misaligned target parks in EXC until redirected
        step(1'b1, 64'h8000_0102, 100, 60, 0);
        base = hs_count;
        for (int i = 0; i < 10; i++) step(1'b0, '0, 100, 100, 50);
        chk("exc_no_fetch", 64'(hs_count - base), 64'd0);
        step(1'b1, 64'h8000_0000, 100, 60, 0);
        base = hs_count;
        for (int i = 0; i < 10; i++) step(1'b0, '0, 100, 100, 50);
        chk("exc_resume", 64'(hs_count - base > 0), 64'd1);

        // 5: odd-word target
        step(1'b1, 64'h8000_0104, 100, 60, 0);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 100, 100, 50);

        // Random traffic with mixed redirect targets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) < 3) begin
                rnd16 = 16'($urandom);
                tgt = {32'd0, 16'h8000, rnd16};
                step(1'b1, tgt, 70, 50, 40);
            end else begin
                step(1'b0, '0, 70, 50, 40);
            end
        end
        if (in_exc) step(1'b1, 64'h8000_0040, 100, 50, 0);

        // 6: asynchronous reset with a response pending
        n = 0;
        while (infl.size() == 0 && n < 20) begin
            step(1'b0, '0, 100, 0, 100);
            n++;
        end
        chk("pending_before_reset", 64'(infl.size() > 0), 64'd1);
        @(posedge clk);
        #1;
        idle_inputs();
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        base = hs_count;
        for (int i = 0; i < 30; i++) step(1'b0, '0, 100, 100, 0);
        chk("post_reset_credits", 64'(hs_count - base), 64'd7);

        // Drain outstanding responses and confirm nothing expected is left behind
        n = 0;
        while (infl.size() > 0 && n < 50) begin
            step(1'b0, '0, 0, 100, 0);
            n++;
        end
        step(1'b0, '0, 0, 0, 0);
        step(1'b0, '0, 0, 0, 0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
